// File: rtl/vnu_extr_accum.sv
// Serial variable-node update: accumulates channel LLR plus check messages, then
// streams out per-message extrinsics (total minus message), saturated, sign-magnitude.
module vnu_extr_accum #(
  parameter int DW      = 6,
  parameter int ACC_W   = 10,
  parameter int DEG_MAX = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_data,
  input  logic          i_corr,
  input  logic          i_first,
  input  logic          i_last,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data,
  output logic          o_last,
  output logic          o_hd,
  output logic          o_err
);

  localparam int CW = $clog2(DEG_MAX + 1);
  localparam int AW = (DEG_MAX > 1) ? $clog2(DEG_MAX) : 1;
  localparam int MW = DW + 1;
  localparam int EW = ACC_W + 1;

  typedef enum logic {ACC, OUT} state_t;

  state_t            state, state_nxt;
  logic              frame_open;
  logic [CW-1:0]     count, rptr;
  logic [ACC_W-1:0]  acc;
  logic [MW-1:0]     buffer [DEG_MAX];

  logic [ACC_W-1:0]  beat_v, acc_after;
  logic [MW-1:0]     beat_m, entry0, next_msg;
  logic [CW-1:0]     count_after, rnext;
  logic              accept, is_msg, msg_ok, msg_ovf, go_out, out_xfer;

  function automatic logic [DW-1:0] extr(input logic [ACC_W-1:0] a,
                                         input logic [MW-1:0] m);
    logic [EW-1:0] e;
    logic [EW-1:0] mag;
    logic [DW-2:0] sat;
    e   = {a[ACC_W-1], a} - {{(EW-MW){m[MW-1]}}, m};
    mag = e[EW-1] ? (EW'(0) - e) : e;
    sat = (mag > EW'(2**(DW-1) - 1)) ? '1 : mag[DW-2:0];
    return {e[EW-1], sat};
  endfunction

  always_comb begin
    beat_v      = {{(ACC_W-DW){i_data[DW-1]}}, i_data} + {{(ACC_W-1){1'b0}}, i_corr};
    beat_m      = {i_data[DW-1], i_data} + {{DW{1'b0}}, i_corr};
    accept      = i_valid && (state == ACC);
    is_msg      = accept && !i_first;
    msg_ok      = is_msg && frame_open && (count < CW'(DEG_MAX));
    msg_ovf     = is_msg && frame_open && (count == CW'(DEG_MAX));
    count_after = msg_ok ? count + CW'(1) : count;
    acc_after   = msg_ok ? acc + beat_v : acc;
    go_out      = is_msg && frame_open && i_last && (count_after != '0);
    // The first message of a frame is still in flight on the last beat when count is 0.
    entry0      = (msg_ok && count == '0) ? beat_m : buffer[0];
    out_xfer    = (state == OUT) && o_valid && i_ready;
    rnext       = rptr + CW'(1);
    next_msg    = buffer[rnext[AW-1:0]];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ACC;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (go_out) state_nxt = OUT;
      OUT:     if (out_xfer && o_last) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_comb begin
    o_ready = (state == ACC);
  end

  always_ff @(posedge i_clk) begin
    if (msg_ok) buffer[count[AW-1:0]] <= beat_m;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      frame_open <= 1'b0;
      count      <= '0;
      rptr       <= '0;
      acc        <= '0;
      o_valid    <= 1'b0;
      o_last     <= 1'b0;
      o_data     <= '0;
      o_hd       <= 1'b0;
      o_err      <= 1'b0;
    end else if (state == ACC) begin
      if (accept && i_first) begin
        acc        <= beat_v;
        count      <= '0;
        frame_open <= 1'b1;
      end else if (is_msg && !frame_open) begin
        o_err <= 1'b1;
      end else if (is_msg) begin
        acc   <= acc_after;
        count <= count_after;
        if (msg_ovf) o_err <= 1'b1;
        if (go_out) begin
          o_valid <= 1'b1;
          o_data  <= extr(acc_after, entry0);
          o_last  <= (count_after == CW'(1));
          o_hd    <= acc_after[ACC_W-1];
          rptr    <= '0;
        end
      end
    end else if (out_xfer) begin
      if (o_last) begin
        o_valid    <= 1'b0;
        o_last     <= 1'b0;
        frame_open <= 1'b0;
      end else begin
        rptr   <= rnext;
        o_data <= extr(acc, next_msg);
        o_last <= (rnext == count - CW'(1));
      end
    end
  end

endmodule

// File: tb/tb_vnu_extr_accum.sv
// Directed self-checking bench for vnu_extr_accum with hand-computed extrinsics.
module tb_vnu_extr_accum;
  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, out_ready_dut, in_corr, in_first, in_last;
  logic [DW-1:0] in_data;
  logic          out_valid, ds_ready, out_last, out_hd, out_err;
  logic [DW-1:0] out_data;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] got_d [16];
  logic          got_l [16];
  int            got_n;
  bit            unstable, rdy_in_out, timed_out;

  always #5 clk = ~clk;

  vnu_extr_accum #(.DW(6), .ACC_W(10), .DEG_MAX(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(out_ready_dut),
    .i_data(in_data), .i_corr(in_corr), .i_first(in_first), .i_last(in_last),
    .o_valid(out_valid), .i_ready(ds_ready), .o_data(out_data), .o_last(out_last),
    .o_hd(out_hd), .o_err(out_err)
  );

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic c, input logic f, input logic l);
    in_valid = 1'b1; in_data = d; in_corr = c; in_first = f; in_last = l;
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_corr = 1'b0;
  endtask

  // Collects outputs until o_last transfers; optionally stalls one output.
  task automatic drain(input int stall_idx, input int stall_cyc);
    int cyc;
    logic [DW-1:0] hd;
    logic hl;
    cyc = 0; got_n = 0; unstable = 0; rdy_in_out = 0; timed_out = 0;
    for (int i = 0; i < 16; i++) begin got_d[i] = 'x; got_l[i] = 1'bx; end
    ds_ready = 1'b1;
    while (1) begin
      if (cyc > 200 || got_n >= 16) begin timed_out = 1; break; end
      if (out_valid) begin
        if (out_ready_dut) rdy_in_out = 1;
        if (got_n == stall_idx) begin
          ds_ready = 1'b0; hd = out_data; hl = out_last;
          repeat (stall_cyc) begin
            @(posedge clk); #1; cyc++;
            if (out_data !== hd || out_last !== hl || out_valid !== 1'b1) unstable = 1;
            if (out_ready_dut) rdy_in_out = 1;
          end
          ds_ready = 1'b1;
        end
        got_d[got_n] = out_data; got_l[got_n] = out_last; got_n++;
        if (out_last) begin @(posedge clk); #1; break; end
      end
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_ready_dut !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", out_ready_dut); end
    checks++; if (out_data !== 6'b000000 || out_last !== 1'b0) begin errors++; $display("FAIL reset_data got %b/%b exp 000000/0", out_data, out_last); end
    checks++; if (out_hd !== 1'b0 || out_err !== 1'b0) begin errors++; $display("FAIL reset_flags hd=%b err=%b exp 0/0", out_hd, out_err); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp_d [3];
    exp_d[0] = 6'b001100; exp_d[1] = 6'b000101; exp_d[2] = 6'b000000;
    send(6'b000011, 1'b0, 1'b1, 1'b0);
    send(6'b111010, 1'b1, 1'b0, 1'b0);
    send(6'b000010, 1'b0, 1'b0, 1'b0);
    send(6'b000111, 1'b0, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency o_valid got %b exp 1", out_valid); end
    checks++; if (out_ready_dut !== 1'b0) begin errors++; $display("FAIL basic_ready_out got %b exp 0", out_ready_dut); end
    drain(-1, 0);
    checks++; if (got_n !== 3 || timed_out) begin errors++; $display("FAIL basic_count got %0d exp 3 (timeout=%0d)", got_n, timed_out); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 2)) begin
        errors++; $display("FAIL basic_out%0d got %b/%b exp %b/%b", i, got_d[i], got_l[i], exp_d[i], (i == 2));
      end
    end
    checks++; if (out_hd !== 1'b0) begin errors++; $display("FAIL basic_hd got %b exp 0", out_hd); end
    checks++; if (out_valid !== 1'b0 || out_ready_dut !== 1'b1) begin errors++; $display("FAIL basic_after valid=%b ready=%b exp 0/1", out_valid, out_ready_dut); end
  endtask

  task automatic test_saturation();
    send(6'b011111, 1'b0, 1'b1, 1'b0);
    send(6'b011111, 1'b0, 1'b0, 1'b0);
    send(6'b011111, 1'b0, 1'b0, 1'b1);
    drain(-1, 0);
    checks++; if (got_n !== 2) begin errors++; $display("FAIL satp_count got %0d exp 2", got_n); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (got_d[i] !== 6'b011111 || got_l[i] !== (i == 1)) begin
        errors++; $display("FAIL satp_out%0d got %b/%b exp 011111/%b", i, got_d[i], got_l[i], (i == 1));
      end
    end
    checks++; if (out_hd !== 1'b0) begin errors++; $display("FAIL satp_hd got %b exp 0", out_hd); end
    send(6'b100000, 1'b1, 1'b1, 1'b0);
    send(6'b100000, 1'b1, 1'b0, 1'b0);
    send(6'b100000, 1'b1, 1'b0, 1'b1);
    drain(-1, 0);
    checks++; if (got_n !== 2) begin errors++; $display("FAIL satn_count got %0d exp 2", got_n); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (got_d[i] !== 6'b111111 || got_l[i] !== (i == 1)) begin
        errors++; $display("FAIL satn_out%0d got %b/%b exp 111111/%b", i, got_d[i], got_l[i], (i == 1));
      end
    end
    checks++; if (out_hd !== 1'b1) begin errors++; $display("FAIL satn_hd got %b exp 1", out_hd); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp_d [3];
    exp_d[0] = 6'b001100; exp_d[1] = 6'b000101; exp_d[2] = 6'b000000;
    send(6'b000011, 1'b0, 1'b1, 1'b0);
    send(6'b111010, 1'b1, 1'b0, 1'b0);
    send(6'b000010, 1'b0, 1'b0, 1'b0);
    send(6'b000111, 1'b0, 1'b0, 1'b1);
    drain(1, 3);
    checks++; if (got_n !== 3) begin errors++; $display("FAIL bp_count got %0d exp 3", got_n); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 2)) begin
        errors++; $display("FAIL bp_out%0d got %b/%b exp %b/%b", i, got_d[i], got_l[i], exp_d[i], (i == 2));
      end
    end
    checks++; if (unstable) begin errors++; $display("FAIL bp_stable got unstable=1 exp 0"); end
    checks++; if (rdy_in_out) begin errors++; $display("FAIL bp_ready_out got o_ready=1 in OUT exp 0"); end
  endtask

  task automatic test_restart();
    send(6'b000011, 1'b0, 1'b1, 1'b0);
    send(6'b000001, 1'b0, 1'b0, 1'b0);
    send(6'b000001, 1'b0, 1'b0, 1'b0);
    send(6'b001010, 1'b0, 1'b1, 1'b0);
    send(6'b000100, 1'b0, 1'b0, 1'b0);
    send(6'b111110, 1'b0, 1'b0, 1'b1);
    drain(-1, 0);
    checks++; if (got_n !== 2) begin errors++; $display("FAIL restart_count got %0d exp 2", got_n); end
    checks++; if (got_d[0] !== 6'b001000 || got_l[0] !== 1'b0) begin errors++; $display("FAIL restart_out0 got %b/%b exp 001000/0", got_d[0], got_l[0]); end
    checks++; if (got_d[1] !== 6'b001110 || got_l[1] !== 1'b1) begin errors++; $display("FAIL restart_out1 got %b/%b exp 001110/1", got_d[1], got_l[1]); end
  endtask

  task automatic test_protocol();
    do_reset();
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL proto_pre_err got %b exp 0", out_err); end
    send(6'b000101, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL proto_err got %b exp 1", out_err); end
    checks++; if (out_valid !== 1'b0 || out_ready_dut !== 1'b1) begin errors++; $display("FAIL proto_drop valid=%b ready=%b exp 0/1", out_valid, out_ready_dut); end
  endtask

  task automatic test_overflow();
    do_reset();
    send(6'b000000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) send(6'b000001, 1'b0, 1'b0, 1'b0);
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL ovf_pre_err got %b exp 0", out_err); end
    send(6'b000001, 1'b0, 1'b0, 1'b1);
    checks++; if (out_err !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL ovf_err err=%b valid=%b exp 1/1", out_err, out_valid); end
    drain(-1, 0);
    checks++; if (got_n !== 8) begin errors++; $display("FAIL ovf_count got %0d exp 8", got_n); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_d[i] !== 6'b000111 || got_l[i] !== (i == 7)) begin
        errors++; $display("FAIL ovf_out%0d got %b/%b exp 000111/%b", i, got_d[i], got_l[i], (i == 7));
      end
    end
  endtask

  task automatic test_reset_mid_out();
    logic [DW-1:0] exp_d [3];
    send(6'b100000, 1'b1, 1'b1, 1'b0);
    send(6'b100000, 1'b1, 1'b0, 1'b0);
    send(6'b100000, 1'b1, 1'b0, 1'b1);
    ds_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_hd !== 1'b1 || out_err !== 1'b1) begin
      errors++; $display("FAIL rmid_pre valid=%b hd=%b err=%b exp 1/1/1", out_valid, out_hd, out_err);
    end
    ds_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_ready_dut !== 1'b1) begin errors++; $display("FAIL rmid_vr valid=%b ready=%b exp 0/1", out_valid, out_ready_dut); end
    checks++; if (out_hd !== 1'b0 || out_err !== 1'b0) begin errors++; $display("FAIL rmid_flags hd=%b err=%b exp 0/0", out_hd, out_err); end
    exp_d[0] = 6'b001100; exp_d[1] = 6'b000101; exp_d[2] = 6'b000000;
    send(6'b000011, 1'b0, 1'b1, 1'b0);
    send(6'b111010, 1'b1, 1'b0, 1'b0);
    send(6'b000010, 1'b0, 1'b0, 1'b0);
    send(6'b000111, 1'b0, 1'b0, 1'b1);
    drain(-1, 0);
    checks++; if (got_n !== 3) begin errors++; $display("FAIL rmid_count got %0d exp 3", got_n); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 2)) begin
        errors++; $display("FAIL rmid_out%0d got %b/%b exp %b/%b", i, got_d[i], got_l[i], exp_d[i], (i == 2));
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_corr = 1'b0;
    in_first = 1'b0; in_last = 1'b0; ds_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_restart();
    test_protocol();
    test_overflow();
    test_reset_mid_out();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vnu_extr_accum.md
Name: vnu_extr_accum

Overview:
- Serial variable-node update stage; sits directly downstream of the sign-magnitude to ones'-complement converter.
- Consumes one complement-coded word plus its +1 correction bit per beat. The first beat of a frame is the channel LLR; the following beats are check-to-variable messages.
- Forms the two's-complement total and buffers the messages, then emits one extrinsic value per message: total minus that message, saturated, in sign-magnitude.
- Also provides the hard decision.

Parameters:
- DW, 6, message width in bits: sign plus DW-1 magnitude bits.
- ACC_W, 10, accumulator width in bits, two's complement.
- DEG_MAX, 8, maximum number of messages per frame (buffer depth).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_valid  in  1  input beat valid
- o_ready  out  1  input accept; beat transfers when i_valid & o_ready
- i_data  in  DW  ones'-complement word (sign in MSB)
- i_corr  in  1  +1 correction from the converter
- i_first  in  1  beat is the channel LLR and opens a frame
- i_last  in  1  beat is the final message of the frame
- o_valid  out  1  extrinsic output valid
- i_ready  in  1  downstream accept
- o_data  out  DW  extrinsic value, sign-magnitude
- o_last  out  1  final extrinsic of the frame
- o_hd  out  1  hard decision, 1 when total < 0
- o_err  out  1  sticky protocol/overflow error

Behaviour:
- Beat value: v = signed(i_data) sign-extended to ACC_W, plus i_corr. Messages are stored as DW+1-bit signed values.
- Reset (synchronous, any state, including mid-output):
  - state = ACC, no frame open.
  - o_valid = 0, o_last = 0, o_data = 0, o_hd = 0, o_err = 0.
  - Count = 0, read pointer = 0, accumulator = 0.
- State ACC: o_ready = 1.
  - i_first beat: acc = v and count = 0; it discards any open frame. i_last on this beat is ignored.
  - Non-first beat with a frame open: acc += v; store v at buffer[count]; count++.
  - Non-first beat with no frame open: drop the beat and set o_err.
  - Message beat when count == DEG_MAX: do not accumulate or store; set o_err. i_last is still honoured.
  - Accepted message beat with i_last and count >= 1 after that beat: go to OUT on the next edge.
- State OUT: o_ready = 0.
  - On entry (first OUT cycle): o_valid = 1 with entry 0 loaded. Latency from i_last accept to o_valid is 1 cycle.
  - o_hd = acc[ACC_W-1], registered at OUT entry and held until the next frame's OUT entry.
  - Each output is e = acc - buffer[k], computed at ACC_W+1 bits.
  - Saturate |e| to 2^(DW-1)-1. Sign = 1 only when e < 0; zero is always emitted as +0.
  - o_data, o_last and o_valid are registered and held stable while o_valid & !i_ready.
  - On o_valid & i_ready: advance k. o_last = 1 on k == count-1.
  - After the o_last transfer: o_valid = 0 next cycle, state ACC, frame closed.
  - Input is never accepted in OUT. Back-to-back frames incur one idle cycle of o_ready after the last output transfer: o_ready re-asserts the cycle after.
- Accumulator cannot overflow for DEG_MAX <= 15 with ACC_W = 10; wider DEG_MAX requires ACC_W >= DW + ceil(log2(DEG_MAX+2)).
- o_err clears only on reset.

Test Plan:
- Basic frame: beats LLR +3 (000011,c0), then -5 (111010,c1), +2 (000010,c0), +7 (000111,c0, last) -> total 7; outputs 001100, 000101, 000000 with o_last on the third; o_hd = 0; o_valid one cycle after the last accept.
- Saturation: LLR +31, messages +31, +31 (last) -> total 93; each output is 62, saturated to 011111. Negative mirror: all -31 -> each output 111111; o_hd = 1.
- Backpressure: same frame as Basic with i_ready low for 3 cycles on output 2 -> o_data / o_last stable, no skipped or duplicated outputs; o_ready = 0 throughout OUT.
- Overflow / protocol: 9 messages with DEG_MAX = 8 -> 8 outputs emitted, o_err = 1. A message beat sent with no open frame -> dropped, o_err = 1.
- Frame restart: i_first issued after 2 messages -> prior data discarded; only the new frame's outputs appear.
- Reset mid-OUT: assert i_rst during output 2 -> next cycle o_valid = 0, o_ready = 1, o_hd = 0, o_err = 0; a fresh frame then processes correctly.
